// File: rtl/div_arbiter.sv
// Round-robin front end that shares one external divider among NUM_REQ requesters.
// A zero divisor is answered locally without starting the divider.
module div_arbiter #(
  parameter int C_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*C_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*C_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic [C_WIDTH-1:0]         resp_q,
  output logic [C_WIDTH-1:0]         resp_r,
  input  logic                       resp_ready,
  output logic                       div_start,
  output logic                       div_ack,
  output logic [C_WIDTH-1:0]         div_a,
  output logic [C_WIDTH-1:0]         div_b,
  input  logic [C_WIDTH-1:0]         div_q,
  input  logic [C_WIDTH-1:0]         div_r,
  input  logic                       div_complete
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  logic [C_WIDTH-1:0] op_a_q, op_a_d;
  logic [C_WIDTH-1:0] op_b_q, op_b_d;
  logic [C_WIDTH-1:0] res_q_q, res_q_d;
  logic [C_WIDTH-1:0] res_r_q, res_r_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_next;
  logic [C_WIDTH-1:0] sel_a, sel_b;
  logic               accept;
  logic               div_active;

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == ID_W'(j)) begin
        sel_a = req_a[j*C_WIDTH +: C_WIDTH];
        sel_b = req_b[j*C_WIDTH +: C_WIDTH];
      end
    end
  end

  assign accept  = grant_found && (state_q == IDLE) && !rst;
  assign rr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = accept && (grant_id == ID_W'(j));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    op_id_d  = op_id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_q_d  = res_q_q;
    res_r_d  = res_r_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_id_d  = grant_id;
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          rr_ptr_d = rr_next;
          if (sel_b == '0) begin
            res_q_d = '1;
            res_r_d = sel_a;
            state_d = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (div_complete) begin
          res_q_d = div_q;
          res_r_d = div_r;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      op_id_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q_q  <= '0;
      res_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_id_q  <= op_id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q_q  <= res_q_d;
      res_r_q  <= res_r_d;
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge lands.
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_id    = resp_valid ? op_id_q : '0;
  assign resp_q     = resp_valid ? res_q_q : '0;
  assign resp_r     = resp_valid ? res_r_q : '0;
  assign div_start  = (state_q == START) && !rst;
  assign div_ack    = (state_q == BUSY) && div_complete && !rst;
  assign div_active = ((state_q == START) || (state_q == BUSY)) && !rst;
  assign div_a      = div_active ? op_a_q : '0;
  assign div_b      = div_active ? op_b_q : '0;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural shared divider and a response scoreboard.
module tb_div_arbiter;
  localparam int CW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*CW-1:0]   req_a;
  logic [NR*CW-1:0]   req_b;
  logic [NR-1:0]      req_ready;
  logic               resp_valid;
  logic [IW-1:0]      resp_id;
  logic [CW-1:0]      resp_q;
  logic [CW-1:0]      resp_r;
  logic               resp_ready;
  logic               div_start;
  logic               div_ack;
  logic [CW-1:0]      div_a;
  logic [CW-1:0]      div_b;
  logic [CW-1:0]      div_q;
  logic [CW-1:0]      div_r;
  logic               div_complete;

  div_arbiter #(.C_WIDTH(CW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r),
    .resp_ready(resp_ready),
    .div_start(div_start), .div_ack(div_ack), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_complete(div_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared divider: completes dm_lat cycles after start, holds complete until ack.
  int          dm_lat = 3;
  int          dm_cnt = 0;
  logic        dm_busy = 1'b0;
  logic        dm_complete = 1'b0;
  logic [CW-1:0] dm_q = '0;
  logic [CW-1:0] dm_r = '0;
  logic        stray;

  always @(posedge clk) begin
    if (rst) begin
      dm_busy     <= 1'b0;
      dm_complete <= 1'b0;
      dm_cnt      <= 0;
    end else if (div_start) begin
      dm_busy     <= 1'b1;
      dm_cnt      <= dm_lat;
      dm_complete <= 1'b0;
    end else if (dm_complete) begin
      if (div_ack) begin
        dm_complete <= 1'b0;
        dm_busy     <= 1'b0;
      end
    end else if (dm_busy) begin
      if (dm_cnt <= 1) begin
        dm_complete <= 1'b1;
        dm_q <= (div_b == '0) ? '1 : div_a / div_b;
        dm_r <= (div_b == '0) ? div_a : div_a % div_b;
      end else begin
        dm_cnt <= dm_cnt - 1;
      end
    end
  end

  assign div_complete = dm_complete | stray;
  assign div_q = dm_q;
  assign div_r = dm_r;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] q;
    logic [CW-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   acc_cyc[$];
  int   start_cyc[$];
  int   ack_cyc[$];
  int   rv_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nstart = 0;
  int   nack = 0;
  int   nresp = 0;
  int   exp_start = 0;
  int   exp_ack = 0;
  logic prev_rv = 1'b0;

  logic [136:0] all_outs;
  assign all_outs = {resp_valid, resp_id, resp_q, resp_r, div_start, div_ack,
                     div_a, div_b, req_ready};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [CW-1:0] a, input logic [CW-1:0] b,
                         input bit expect_resp);
    exp_t e;
    req_a[id*CW +: CW] = a;
    req_b[id*CW +: CW] = b;
    req_valid[id] = 1'b1;
    if (b != '0) exp_start++;
    if (expect_resp) begin
      e.id = IW'(id);
      e.q  = (b == '0) ? '1 : a / b;
      e.r  = (b == '0) ? a : a % b;
      sb.push_back(e);
      if (b != '0) exp_ack++;
    end
  endtask

  // One clock: observe mid-cycle, take the edge, drop the accepted request.
  task automatic cycle();
    bit   acc_pend;
    int   acc_g;
    exp_t e;
    #2;
    acc_pend = 1'b0;
    acc_g = 0;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_pend = 1'b1;
        acc_g = i;
      end
    end
    if (acc_pend) begin
      grants.push_back(acc_g);
      acc_cyc.push_back(cyc);
    end
    if (div_start) begin nstart++; start_cyc.push_back(cyc); end
    if (div_ack)   begin nack++;   ack_cyc.push_back(cyc);   end
    if (resp_valid && !prev_rv) rv_cyc.push_back(cyc);
    prev_rv = resp_valid;
    if (resp_valid && resp_ready) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_q", resp_q, e.q);
        chk("resp_r", resp_r, e.r);
      end
      nresp++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (acc_pend) req_valid[acc_g] = 1'b0;
  endtask

  task automatic run_until_resp(input int n, input int budget, input string tag);
    int target = nresp + n;
    int k = 0;
    while (nresp < target && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, nresp, target);
  endtask

  initial begin
    int g0;
    int ns0;
    int rel;
    rst = 1'b1;
    resp_ready = 1'b1;
    stray = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;

    // All four requesters pending through reset; covers plain, /1, /0 and a fourth divide.
    set_req(0, 32'd100, 32'd7, 1'b1);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    set_req(2, 32'h1234, 32'd0, 1'b1);
    set_req(3, 32'd1000, 32'd33, 1'b1);
    repeat (3) cycle();
    chk("rst_outs", all_outs, '0);
    rst = 1'b0;
    run_until_resp(4, 200, "respA_count");
    chk("grantA0", grants[0], 0);
    chk("grantA1", grants[1], 1);
    chk("grantA2", grants[2], 2);
    chk("grantA3", grants[3], 3);
    chk("startsA", nstart, 3);
    chk("acksA", nack, 3);
    chk("lat_start0", start_cyc[0], acc_cyc[0] + 1);
    chk("lat_resp0", rv_cyc[0], ack_cyc[0] + 1);
    chk("lat_div0", rv_cyc[2], acc_cyc[2] + 1);
    chk("lat_start3", start_cyc[2], acc_cyc[3] + 1);

    // Requests 1 and 3 together with the pointer back at 0.
    dm_lat = 5;
    g0 = grants.size();
    set_req(1, 32'd77, 32'd5, 1'b1);
    set_req(3, 32'd9, 32'd10, 1'b1);
    run_until_resp(2, 100, "respB_count");
    chk("grantB0", grants[g0], 1);
    chk("grantB1", grants[g0+1], 3);

    // Consumer stalls while another request waits.
    dm_lat = 1;
    resp_ready = 1'b0;
    g0 = grants.size();
    set_req(0, 32'd50, 32'd6, 1'b1);
    set_req(2, 32'd60, 32'd7, 1'b1);
    for (int k = 0; k < 40 && !resp_valid; k++) cycle();
    chk("stall_rv", resp_valid, 1);
    ns0 = nstart;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("hold_resp", {resp_valid, resp_id, resp_q, resp_r}, {1'b1, sb[0]});
      chk("hold_ready", req_ready, '0);
    end
    chk("hold_nostart", nstart, ns0);
    resp_ready = 1'b1;
    run_until_resp(2, 100, "respC_count");
    chk("grantC0", grants[g0], 0);
    chk("grantC1", grants[g0+1], 2);

    // Stray divider completion while idle.
    stray = 1'b1;
    #1;
    chk("stray_ack", div_ack, 0);
    cycle();
    chk("stray_rv", resp_valid, 0);
    stray = 1'b0;

    // Reset during BUSY abandons the operation; pointer must return to 0.
    dm_lat = 8;
    ns0 = nstart;
    set_req(1, 32'd1000, 32'd3, 1'b0);
    for (int k = 0; k < 20 && nstart == ns0; k++) cycle();
    cycle();
    cycle();
    chk("busy_div_ab", {div_a, div_b}, {32'd1000, 32'd3});
    rst = 1'b1;
    cycle();
    chk("rst_busy_outs", all_outs, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_outs", all_outs, '0);
    g0 = grants.size();
    rel = cyc;
    set_req(1, 32'd5, 32'd9, 1'b1);
    set_req(3, 32'd20, 32'd4, 1'b1);
    run_until_resp(2, 100, "respE_count");
    chk("first_acc_after_rst", acc_cyc[g0], rel);
    chk("grantE0", grants[g0], 1);
    chk("grantE1", grants[g0+1], 3);

    repeat (3) cycle();
    chk("n_start", nstart, exp_start);
    chk("n_ack", nack, exp_ack);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- C_WIDTH, 32, operand/result width.
- NUM_REQ, 4, requester count (2..16).
- ID_W, max(1,clog2(NUM_REQ)), requester id width.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- req_valid, in, NUM_REQ, per-requester request.
- req_a, in, NUM_REQ*C_WIDTH, dividends; requester i at [i*C_WIDTH +: C_WIDTH].
- req_b, in, NUM_REQ*C_WIDTH, divisors; same packing.
- req_ready, out, NUM_REQ, accept strobe.
- resp_valid, out, 1, result available.
- resp_id, out, ID_W, requester index of result.
- resp_q, out, C_WIDTH, quotient.
- resp_r, out, C_WIDTH, remainder.
- resp_ready, in, 1, consumer accepts result.
- div_start, out, 1, start pulse to shared divider.
- div_ack, out, 1, acknowledge pulse to shared divider.
- div_a, out, C_WIDTH, divider dividend.
- div_b, out, C_WIDTH, divider divisor.
- div_q, in, C_WIDTH, divider quotient.
- div_r, in, C_WIDTH, divider remainder.
- div_complete, in, 1, divider done, held until div_ack.

REQ-003 The divider's reset is driven from the same rst; no other divider control exists.

Function
REQ-004 FSM states: IDLE, START, BUSY, RESP; one-hot or encoded.
REQ-005 IDLE: req_ready[g] is high combinationally for exactly one g, the round-robin winner among set req_valid bits, searching upward from rr_ptr with wrap; all req_ready bits are low in every other state, or when no req_valid bit is set.
REQ-006 Accept = req_valid[g] & req_ready[g]. On accept:
- latch A, B and g into op_a, op_b, op_id;
- rr_ptr <= (g+1) mod NUM_REQ.
REQ-007 Accept with B != 0 goes to START. Accept with B == 0 goes directly to RESP with resp_q = all ones and resp_r = A; the divider is not started.
REQ-008 START lasts exactly one cycle with div_start = 1, then goes to BUSY.
REQ-009 div_a = op_a and div_b = op_b, held constant from START until leaving BUSY.
REQ-010 BUSY: hold until div_complete = 1. In that cycle:
- capture div_q and div_r into resp_q and resp_r;
- assert div_ack for exactly one cycle;
- go to RESP.
REQ-011 div_complete seen in any state other than BUSY is ignored.
REQ-012 RESP: resp_valid = 1, and resp_id, resp_q, resp_r stay stable until resp_valid & resp_ready; that handshake returns to IDLE.
REQ-013 Single outstanding operation. A new accept may occur no earlier than the cycle after the RESP handshake.
REQ-014 Latency: accept at cycle T gives div_start at T+1; resp_valid the cycle after div_complete is first seen; divide-by-zero gives resp_valid at T+1.
REQ-015 Requesters hold req_valid, req_a and req_b stable until accepted. A requester that drops req_valid before acceptance is simply not granted.
REQ-016 Operands are unsigned; results are not modified except in the divide-by-zero case.
REQ-017 Simultaneous requests: only the winner is accepted; the others remain pending and keep their position in the round-robin order.

Reset
REQ-018 While rst = 1:
- state goes to IDLE and rr_ptr to 0;
- resp_valid, resp_id, resp_q, resp_r, div_start, div_ack, div_a, div_b and all req_ready bits are 0.
REQ-019 rst in any state, including START, BUSY or RESP, abandons the operation without a response; the first accept may occur the cycle after rst deasserts.

Verification
REQ-020 Req 0, A=100, B=7 -> one div_start pulse; resp_id=0, Q=14, R=2; exactly one div_ack pulse.
REQ-021 Req 2, A=0x1234, B=0 -> resp_valid at T+1, Q=0xFFFFFFFF, R=0x1234; div_start never asserted.
REQ-022 Requests 0-3 all valid from reset, resp_ready=1 -> grant order 0,1,2,3. Then requests 1 and 3 valid with rr_ptr=0 -> grants 1, then 3.
REQ-023 resp_ready=0 for 10 cycles in RESP while requests are pending -> resp_valid/id/q/r stable, req_ready all 0, no div_start.
REQ-024 rst pulsed during BUSY -> next cycle all outputs 0 and rr_ptr=0; afterwards A=5, B=9 from req 1 -> Q=0, R=5, id=1.
REQ-025 A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0, passed through the divider (div_start observed).
